shift_register_param: RTL and testbench

Parametrised universal shift register, the successor to the fixed 8-bit four-mode shift register in the benchmark designs. It adds a configurable width, a multi-bit shift distance, rotate and arithmetic modes, and a burst engine that runs a latched operation for a programmed number of cycles. It sits in the shift_register testcase as the DUT mapped onto the FPGA fabric, and is driven directly from pads through the pin-assignment file.

---
 rtl/shift_register_param_if.sv | 41 ++++
 rtl/shift_register_param.sv | 179 +++++++++++++++++
 tb/tb_shift_register_param.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : shift_register_param_if
//  Purpose  : Bundles the control, data and status signals of the
//             parametrised universal shift register.
//  Ports    : (interface signals)
//     en, mode, amt, sin, data, start, burst_len  - driven by the master
//     q_reg, sout_msb, sout_lsb, busy, done       - driven by the slave
//  Modports : master (stimulus side), slave (shift register side)
//  Revision : 1.0  initial release
// ============================================================================
interface shift_register_param_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) ();

  logic             en;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic             sin;
  logic [WIDTH-1:0] data;
  logic             start;
  logic [7:0]       burst_len;
  logic [WIDTH-1:0] q_reg;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, amt, sin, data, start, burst_len,
    input  q_reg, sout_msb, sout_lsb, busy, done
  );

  modport slave (
    input  en, mode, amt, sin, data, start, burst_len,
    output q_reg, sout_msb, sout_lsb, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/shift_register_param.sv
`default_nettype none
// ============================================================================
//  Module   : shift_register_param
//  Purpose  : Parametrised universal shift register with multi-bit logical,
//             arithmetic and rotate shifts plus a burst engine that repeats a
//             latched operation for a programmed number of cycles.
//  Ports    :
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset, clears all state
//     bus    slave modport of shift_register_param_if
//              en/mode/amt/sin/data  direct operation controls
//              start/burst_len       burst launch
//              q_reg                 registered contents
//              sout_msb/sout_lsb     combinational taps of q_reg ends
//              busy/done             registered burst status
//  Revision : 1.0  initial release
// ============================================================================
module shift_register_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  shift_register_param_if.slave bus
);

  // Mode encoding
  localparam logic [2:0] c_mode_hold = 3'd0;
  localparam logic [2:0] c_mode_shr  = 3'd1;
  localparam logic [2:0] c_mode_shl  = 3'd2;
  localparam logic [2:0] c_mode_load = 3'd3;
  localparam logic [2:0] c_mode_ror  = 3'd4;
  localparam logic [2:0] c_mode_rol  = 3'd5;
  localparam logic [2:0] c_mode_asr  = 3'd6;

  // AMT_W = clog2(WIDTH), so WIDTH always fits in AMT_W+1 bits.
  localparam logic [AMT_W:0] c_width = WIDTH[AMT_W:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic [2:0]       r_sh_mode;
  logic [2:0]       w_sh_mode_next;
  logic [AMT_W-1:0] r_sh_amt;
  logic [AMT_W-1:0] w_sh_amt_next;
  logic             r_busy;
  logic             r_done;

  // --------------------------------------------------------------------------
  // Operation datapath. During a burst the shadowed mode/amt are used; sin
  // and data are always the live inputs.
  // --------------------------------------------------------------------------
  logic [2:0]         w_op_mode;
  logic [AMT_W-1:0]   w_op_amt;
  logic [AMT_W:0]     w_amt_p1;
  logic [AMT_W:0]     w_dist;
  logic               w_fill;
  logic [WIDTH-1:0]   w_fill_vec;
  logic [2*WIDTH-1:0] w_shr_wide;
  logic [2*WIDTH-1:0] w_shl_wide;
  logic [2*WIDTH-1:0] w_ror_wide;
  logic [2*WIDTH-1:0] w_rol_wide;
  logic [WIDTH-1:0]   w_op_result;

  assign w_op_mode = (r_state == ST_RUN) ? r_sh_mode : bus.mode;
  assign w_op_amt  = (r_state == ST_RUN) ? r_sh_amt  : bus.amt;

  // Distance d = amt+1. For non power-of-two widths amt can encode more than
  // WIDTH, so clamp; a full-width shift already gives the saturated result.
  assign w_amt_p1 = {1'b0, w_op_amt} + {{AMT_W{1'b0}}, 1'b1};
  assign w_dist   = (w_amt_p1 > c_width) ? c_width : w_amt_p1;

  // Arithmetic right shift fills with the old sign bit, logical with sin.
  assign w_fill     = (w_op_mode == c_mode_asr) ? r_q[WIDTH-1] : bus.sin;
  assign w_fill_vec = {WIDTH{w_fill}};

  // Double-width vectors let a single barrel shift produce both the moved
  // bits and the fill (or wrapped) bits, including the d = WIDTH case.
  assign w_shr_wide = {w_fill_vec, r_q} >> w_dist;
  assign w_shl_wide = {r_q, w_fill_vec} << w_dist;
  assign w_ror_wide = {r_q, r_q} >> w_dist;
  assign w_rol_wide = {r_q, r_q} << w_dist;

  always_comb begin
    w_op_result = r_q;
    case (w_op_mode)
      c_mode_hold: w_op_result = r_q;
      c_mode_shr:  w_op_result = w_shr_wide[WIDTH-1:0];
      c_mode_shl:  w_op_result = w_shl_wide[2*WIDTH-1:WIDTH];
      c_mode_load: w_op_result = bus.data;
      c_mode_ror:  w_op_result = w_ror_wide[WIDTH-1:0];
      c_mode_rol:  w_op_result = w_rol_wide[2*WIDTH-1:WIDTH];
      c_mode_asr:  w_op_result = w_shr_wide[WIDTH-1:0];
      default:     w_op_result = r_q;   // reserved mode holds
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst control: next-state and next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_q_next       = r_q;
    w_cnt_next     = r_cnt;
    w_sh_mode_next = r_sh_mode;
    w_sh_amt_next  = r_sh_amt;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          // The launch cycle only latches; the first op runs next edge.
          if (bus.burst_len != 8'd0) begin
            w_sh_mode_next = bus.mode;
            w_sh_amt_next  = bus.amt;
            w_cnt_next     = bus.burst_len;
            w_state_next   = ST_RUN;
          end else begin
            w_state_next   = ST_FIN;
          end
        end else if (bus.en) begin
          w_q_next = w_op_result;
        end
      end
      ST_RUN: begin
        w_q_next   = w_op_result;
        w_cnt_next = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. busy/done are registered from the next state so they
  // line up with the state they describe without a combinational decode.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_cnt     <= 8'd0;
      r_sh_mode <= 3'd0;
      r_sh_amt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_q       <= w_q_next;
      r_cnt     <= w_cnt_next;
      r_sh_mode <= w_sh_mode_next;
      r_sh_amt  <= w_sh_amt_next;
      r_busy    <= (w_state_next == ST_RUN);
      r_done    <= (w_state_next == ST_FIN);
    end
  end

  assign bus.q_reg    = r_q;
  assign bus.sout_msb = r_q[WIDTH-1];
  assign bus.sout_lsb = r_q[0];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_register_param
//  Purpose  : Self-checking bench for shift_register_param (WIDTH=8). A
//             bit-level reference model predicts q_reg/busy/done for every
//             clock; predictions are queued when stimulus is applied and
//             compared once the DUT has clocked. Directed scenarios add
//             literal checks of the documented results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_register_param;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;

  shift_register_param_if #(.WIDTH(WIDTH)) bus ();

  shift_register_param #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_errors;
  int done_seen;

  // Reference model state: 0 idle, 1 run, 2 fin
  logic [7:0] m_q;
  int         m_state;
  int         m_cnt;
  logic [2:0] m_mode;
  logic [2:0] m_amt;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] model_op(input logic [7:0] q,
                                          input logic [2:0] m,
                                          input logic [2:0] a,
                                          input logic s,
                                          input logic [7:0] dat);
    logic [7:0] r;
    int d;
    r = q;
    d = int'(a) + 1;
    for (int i = 0; i < 8; i++) begin
      case (m)
        3'd1: r[i] = (i + d < 8) ? q[i+d] : s;
        3'd2: r[i] = (i - d >= 0) ? q[i-d] : s;
        3'd4: r[i] = q[(i + d) % 8];
        3'd5: r[i] = q[(i - d + 8) % 8];
        3'd6: r[i] = (i + d < 8) ? q[i+d] : q[7];
        default: r[i] = q[i];
      endcase
    end
    if (m == 3'd3) r = dat;
    return r;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step(output exp_t e);
    if (reset) begin
      m_q = 8'h00; m_state = 0; m_cnt = 0;
    end else begin
      case (m_state)
        0: begin
          if (bus.start) begin
            if (bus.burst_len != 8'd0) begin
              m_mode = bus.mode; m_amt = bus.amt;
              m_cnt = int'(bus.burst_len); m_state = 1;
            end else begin
              m_state = 2;
            end
          end else if (bus.en) begin
            m_q = model_op(m_q, bus.mode, bus.amt, bus.sin, bus.data);
          end
        end
        1: begin
          m_q = model_op(m_q, m_mode, m_amt, bus.sin, bus.data);
          if (m_cnt == 1) m_state = 2;
          m_cnt = m_cnt - 1;
        end
        default: m_state = 0;
      endcase
    end
    e.q    = m_q;
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
  endtask

  task automatic step();
    exp_t e;
    model_step(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("q_reg",    32'(bus.q_reg),    32'(e.q));
      check_eq("busy",     32'(bus.busy),     32'(e.busy));
      check_eq("done",     32'(bus.done),     32'(e.done));
      check_eq("sout_msb", 32'(bus.sout_msb), 32'(e.q[7]));
      check_eq("sout_lsb", 32'(bus.sout_lsb), 32'(e.q[0]));
    end
    if (bus.done) done_seen++;
  endtask

  task automatic direct(input logic [2:0] m, input logic [2:0] a,
                        input logic s, input logic [7:0] dat);
    bus.en = 1'b1; bus.mode = m; bus.amt = a; bus.sin = s; bus.data = dat;
    step();
    bus.en = 1'b0;
  endtask

  logic [7:0] legacy_exp [4];
  logic       legacy_sin [4];

  initial begin
    n_checks = 0; n_errors = 0; done_seen = 0;
    m_q = 8'h00; m_state = 0; m_cnt = 0; m_mode = 3'd0; m_amt = 3'd0;
    reset = 1'b1;
    bus.en = 1'b0; bus.mode = 3'd0; bus.amt = 3'd0; bus.sin = 1'b0;
    bus.data = 8'h00; bus.start = 1'b0; bus.burst_len = 8'd0;

    // Reset state
    step(); step();
    check_eq("reset_q", 32'(bus.q_reg), 32'h00);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Legacy right shift
    legacy_sin[0] = 1'b1; legacy_sin[1] = 1'b0;
    legacy_sin[2] = 1'b0; legacy_sin[3] = 1'b1;
    legacy_exp[0] = 8'h80; legacy_exp[1] = 8'h40;
    legacy_exp[2] = 8'h20; legacy_exp[3] = 8'h90;
    for (int i = 0; i < 4; i++) begin
      direct(3'd1, 3'd0, legacy_sin[i], 8'h00);
      check_eq("legacy_shr", 32'(bus.q_reg), 32'(legacy_exp[i]));
    end

    // Arithmetic and full-width left shifts
    direct(3'd3, 3'd0, 1'b0, 8'hB1);
    direct(3'd6, 3'd2, 1'b0, 8'h00);
    check_eq("asr_d3", 32'(bus.q_reg), 32'hF6);
    direct(3'd3, 3'd0, 1'b0, 8'hB1);
    direct(3'd2, 3'd7, 1'b1, 8'h00);
    check_eq("shl_d8", 32'(bus.q_reg), 32'hFF);

    // Rotates
    direct(3'd3, 3'd0, 1'b0, 8'h81);
    direct(3'd5, 3'd2, 1'b0, 8'h00);
    check_eq("rol_d3", 32'(bus.q_reg), 32'h0C);
    direct(3'd4, 3'd7, 1'b0, 8'h00);
    check_eq("ror_d8", 32'(bus.q_reg), 32'h0C);

    // Burst of 5 left shifts; live inputs during the burst are ignored
    direct(3'd3, 3'd0, 1'b0, 8'h01);
    bus.start = 1'b1; bus.mode = 3'd2; bus.amt = 3'd0;
    bus.burst_len = 8'd5; bus.sin = 1'b0;
    step();
    check_eq("burst_busy_t0", 32'(bus.busy), 32'd1);
    bus.start = 1'b0; bus.en = 1'b1; bus.mode = 3'd1; bus.amt = 3'd3;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2) ? 1'b1 : 1'b0;
      bus.burst_len = (i == 2) ? 8'd0 : 8'd5;
      step();
    end
    check_eq("burst_result", 32'(bus.q_reg), 32'h20);
    check_eq("burst_done", 32'(bus.done), 32'd1);
    bus.en = 1'b0;
    step();
    check_eq("burst_done_count", 32'(done_seen), 32'd1);

    // Zero-length burst
    bus.start = 1'b1; bus.burst_len = 8'd0;
    step();
    check_eq("zero_done", 32'(bus.done), 32'd1);
    check_eq("zero_busy", 32'(bus.busy), 32'd0);
    check_eq("zero_q", 32'(bus.q_reg), 32'h20);
    bus.start = 1'b0;
    step();

    // Reset mid-burst, with start asserted alongside reset
    bus.start = 1'b1; bus.mode = 3'd5; bus.amt = 3'd0; bus.burst_len = 8'd10;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    check_eq("mid_burst_q", 32'(bus.q_reg), 32'h01);
    done_seen = 0;
    reset = 1'b1; bus.start = 1'b1;
    step();
    check_eq("abort_q", 32'(bus.q_reg), 32'h00);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0; bus.start = 1'b0;
    repeat (3) step();
    check_eq("abort_no_done", 32'(done_seen), 32'd0);

    // Back-to-back bursts with start held high
    direct(3'd3, 3'd0, 1'b0, 8'h5A);
    bus.start = 1'b1; bus.mode = 3'd4; bus.amt = 3'd1; bus.burst_len = 8'd2;
    repeat (10) step();
    bus.start = 1'b0;
    repeat (3) step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      bus.en        = 1'($urandom_range(0, 1));
      bus.mode      = 3'($urandom_range(0, 7));
      bus.amt       = 3'($urandom_range(0, 7));
      bus.sin       = 1'($urandom_range(0, 1));
      bus.data      = 8'($urandom_range(0, 255));
      bus.start     = ($urandom_range(0, 5) == 0);
      bus.burst_len = 8'($urandom_range(0, 6));
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
